// File: rtl/veer_types.sv
// Shared types for the posit issue controller: op packet, issuer states,
// and the operand negation helper used to turn a sub into an add.
package veer_types;

    typedef struct packed {
        logic valid;
        logic add;
        logic sub;
        logic mul;
        logic div;
    } posu_pkt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WB   = 2'd2
    } posu_state_e;

    localparam posu_pkt_t   POSU_PKT_ADD = '{valid: 1'b1, add: 1'b1, sub: 1'b0, mul: 1'b0, div: 1'b0};
    localparam logic [15:0] LAT_MAX      = 16'hFFFF;

    // Two's complement negation; NaR (0x80000000) and zero map to themselves.
    function automatic logic [31:0] posit_neg(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/exu_posu_wdog.sv
// Watchdog for the posit issuer: counts BUSY cycles and flags the cycle in
// which the count reaches TIMEOUT_CYCLES; timeout is the registered pulse.
module exu_posu_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    input  logic cancel,
    output logic expire,
    output logic timeout
);

    localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_r;
    logic          timeout_r;

    // A finishing or flushed op is never reported as timed out.
    always_comb begin
        expire = run & (cnt_r == LIMIT) & ~cancel;
    end

    // Count completed BUSY cycles since the op was issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (run && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // One-cycle pulse, aligned with the issuer's return to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= expire;
        end
    end

    assign timeout = timeout_r;

endmodule

// File: rtl/exu_posu_issue_ctl.sv
// Issue controller between the decoder and the posit unit (exu_posu_ctl):
// issues add/sub, rejects mul/div, handles writeback and flush.
// Optional watchdog enabled with `define RV_POSU_TIMEOUT_EN.
module exu_posu_issue_ctl
    import veer_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    input  posu_pkt_t   dec_pkt,
    input  logic [31:0] dec_rs1,
    input  logic [31:0] dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic        flush,
    output logic        dec_busy,
    output logic        posu_valid,
    output logic [31:0] posu_a,
    output logic [31:0] posu_b,
    output posu_pkt_t   posu_dp,
    input  logic        posu_finish,
    input  logic [31:0] posu_out,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    input  logic        wb_ready,
    output logic        illegal,
    output logic [15:0] last_lat,
    output logic        timeout
);

    posu_state_e state_r, state_nxt_s;
    logic [31:0] a_r, b_r, res_r;
    posu_pkt_t   dp_r;
    logic [4:0]  rd_r;
    logic [15:0] lat_cnt_r, lat_inc_s, last_lat_r;
    logic        illegal_r;
    logic        op_ok_s, op_bad_s, is_sub_s, busy_s;
    logic        load_s, finish_s, illegal_nxt_s, wdog_expire_s;

    // Decode the offered op; a flush kills whatever the decoder presents.
    always_comb begin
        op_ok_s   = dec_valid & dec_pkt.valid & (dec_pkt.add | dec_pkt.sub) & ~flush;
        op_bad_s  = dec_valid & dec_pkt.valid & ~(dec_pkt.add | dec_pkt.sub)
                  & (dec_pkt.mul | dec_pkt.div) & ~flush;
        is_sub_s  = dec_pkt.sub & ~dec_pkt.add;
        busy_s    = (state_r == BUSY);
        lat_inc_s = (lat_cnt_r == LAT_MAX) ? LAT_MAX : lat_cnt_r + 16'd1;
    end

    // Next-state logic; flush has priority over finish, ready and new ops.
    always_comb begin
        state_nxt_s   = state_r;
        load_s        = 1'b0;
        finish_s      = 1'b0;
        illegal_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (op_ok_s) begin
                    state_nxt_s = BUSY;
                    load_s      = 1'b1;
                end else if (op_bad_s) begin
                    illegal_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_nxt_s = IDLE;
                end else if (posu_finish) begin
                    finish_s    = 1'b1;
                    state_nxt_s = (rd_r == 5'd0) ? IDLE : WB;
                end else if (wdog_expire_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            WB: begin
                if (flush) begin
                    state_nxt_s = IDLE;
                end else if (wb_ready) begin
                    if (op_ok_s) begin
                        // retire and issue in the same cycle
                        state_nxt_s = BUSY;
                        load_s      = 1'b1;
                    end else begin
                        state_nxt_s   = IDLE;
                        illegal_nxt_s = op_bad_s;
                    end
                end else begin
                    state_nxt_s = WB;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Decoder back-pressure; WB releases the decoder in the cycle it retires.
    always_comb begin
        case (state_r)
            IDLE:    dec_busy = 1'b0;
            WB:      dec_busy = ~wb_ready;
            default: dec_busy = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture; these stay frozen for the whole BUSY period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r  <= 32'd0;
            b_r  <= 32'd0;
            dp_r <= '0;
            rd_r <= 5'd0;
        end else if (load_s) begin
            a_r  <= dec_rs1;
            b_r  <= is_sub_s ? posit_neg(dec_rs2) : dec_rs2;
            dp_r <= POSU_PKT_ADD;
            rd_r <= dec_rd;
        end
    end

    // Result capture and issue-to-finish latency tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_r      <= 32'd0;
            lat_cnt_r  <= 16'd0;
            last_lat_r <= 16'd0;
        end else begin
            if (finish_s) begin
                res_r      <= posu_out;
                last_lat_r <= lat_inc_s;
            end
            if (load_s) begin
                lat_cnt_r <= 16'd0;
            end else if (busy_s) begin
                lat_cnt_r <= lat_inc_s;
            end
        end
    end

    // Illegal-op pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= illegal_nxt_s;
        end
    end

`ifdef RV_POSU_TIMEOUT_EN
    exu_posu_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (load_s),
        .run     (busy_s),
        .cancel  (flush | posu_finish),
        .expire  (wdog_expire_s),
        .timeout (timeout)
    );
`else
    assign wdog_expire_s = 1'b0;
    assign timeout       = 1'b0;
`endif

    assign posu_valid = busy_s;
    assign posu_a     = a_r;
    assign posu_b     = b_r;
    assign posu_dp    = dp_r;
    assign wb_valid   = (state_r == WB);
    assign wb_rd      = rd_r;
    assign wb_data    = res_r;
    assign illegal    = illegal_r;
    assign last_lat   = last_lat_r;

endmodule

// File: tb/tb_exu_posu_issue_ctl.sv
// Self-checking bench for exu_posu_issue_ctl: directed vector table, hand
// sequences for zero-bubble/reset/watchdog, and randomized transactions.
module tb_exu_posu_issue_ctl;
    import veer_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    posu_pkt_t   dec_pkt;
    logic [31:0] dec_rs1, dec_rs2;
    logic [4:0]  dec_rd;
    logic        flush;
    logic        dec_busy, posu_valid;
    logic [31:0] posu_a, posu_b;
    posu_pkt_t   posu_dp;
    logic        posu_finish;
    logic [31:0] posu_out;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        illegal;
    logic [15:0] last_lat;
    logic        timeout;

    always #5 clk = ~clk;

    exu_posu_issue_ctl #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_pkt(dec_pkt),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .flush(flush),
        .dec_busy(dec_busy), .posu_valid(posu_valid), .posu_a(posu_a),
        .posu_b(posu_b), .posu_dp(posu_dp), .posu_finish(posu_finish),
        .posu_out(posu_out), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_ready(wb_ready), .illegal(illegal),
        .last_lat(last_lat), .timeout(timeout)
    );

    int checks  = 0;
    int errors  = 0;
    int exp_lat = 0;

    typedef struct {
        int          op;     // 0 add, 1 sub, 2 mul, 3 div
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] exp_b;
        logic [4:0]  rd;
        int          d;      // BUSY cycle in which the unit finishes
        int          w;      // WB cycles with wb_ready low
        int          fmode;  // 0 none, 1 flush with finish, 2 flush with wb_ready
        logic [31:0] res;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    function automatic posu_pkt_t mk_pkt(input int op);
        posu_pkt_t p;
        p       = '0;
        p.valid = 1'b1;
        case (op)
            0:       p.add = 1'b1;
            1:       p.sub = 1'b1;
            2:       p.mul = 1'b1;
            default: p.div = 1'b1;
        endcase
        return p;
    endfunction

    function automatic posu_pkt_t add_pkt();
        posu_pkt_t p;
        p       = '0;
        p.valid = 1'b1;
        p.add   = 1'b1;
        return p;
    endfunction

    // One transaction from IDLE back to IDLE; expectations come from the arguments.
    task automatic run_op(input int op, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] exp_b, input logic [4:0] rd, input int d,
                          input int w, input int fmode, input logic [31:0] res);
        dec_valid = 1'b1; dec_pkt = mk_pkt(op);
        dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
        settle();
        chk("idle_dec_busy", 32'(dec_busy), 32'd0);
        next_cycle();
        dec_valid = 1'b0; dec_pkt = '0;
        if (op >= 2) begin
            settle();
            chk("illegal_pulse", 32'(illegal), 32'd1);
            chk("illegal_no_issue", 32'(posu_valid), 32'd0);
            chk("illegal_dec_busy", 32'(dec_busy), 32'd0);
            next_cycle();
            settle();
            chk("illegal_once", 32'(illegal), 32'd0);
            chk("illegal_still_idle", 32'(posu_valid), 32'd0);
            next_cycle();
            return;
        end
        for (int k = 1; k <= d; k++) begin
            if (k == d) begin
                posu_finish = 1'b1; posu_out = res; flush = (fmode == 1);
            end
            settle();
            chk("busy_valid", 32'(posu_valid), 32'd1);
            chk("busy_dec_busy", 32'(dec_busy), 32'd1);
            chk("busy_a", posu_a, rs1);
            chk("busy_b", posu_b, exp_b);
            chk("busy_dp", 32'(posu_dp), 32'(add_pkt()));
            chk("busy_no_wb", 32'(wb_valid), 32'd0);
            chk("busy_timeout", 32'(timeout), 32'd0);
            next_cycle();
        end
        posu_finish = 1'b0; flush = 1'b0;
        if (fmode == 1 || rd == 5'd0) begin
            if (fmode != 1) exp_lat = d;
            settle();
            chk("nowb_wb_valid", 32'(wb_valid), 32'd0);
            chk("nowb_idle", 32'(posu_valid), 32'd0);
            chk("nowb_last_lat", 32'(last_lat), 32'(exp_lat));
            next_cycle();
            return;
        end
        exp_lat = d;
        for (int j = 0; j <= w; j++) begin
            wb_ready = (j == w);
            flush = (fmode == 2) && (j == w);
            posu_finish = 1'b1; posu_out = ~res;   // must be ignored outside BUSY
            settle();
            chk("wb_valid", 32'(wb_valid), 32'd1);
            chk("wb_rd", 32'(wb_rd), 32'(rd));
            chk("wb_data", wb_data, res);
            chk("wb_last_lat", 32'(last_lat), 32'(exp_lat));
            chk("wb_dec_busy", 32'(dec_busy), (j == w) ? 32'd0 : 32'd1);
            next_cycle();
        end
        wb_ready = 1'b0; flush = 1'b0; posu_finish = 1'b0;
        settle();
        chk("retired_wb_valid", 32'(wb_valid), 32'd0);
        chk("retired_idle", 32'(posu_valid), 32'd0);
        next_cycle();
    endtask

    initial begin
        rst = 1'b1; dec_valid = 1'b0; dec_pkt = '0; dec_rs1 = 32'd0; dec_rs2 = 32'd0;
        dec_rd = 5'd0; flush = 1'b0; posu_finish = 1'b0; posu_out = 32'd0; wb_ready = 1'b0;

        tbl[0] = '{0, 32'h40000000, 32'h40000000, 32'h40000000, 5'd5,  3, 0, 0, 32'h48000000};
        tbl[1] = '{1, 32'h12345678, 32'h40000000, 32'hC0000000, 5'd7,  2, 1, 0, 32'h3C000000};
        tbl[2] = '{1, 32'h00000001, 32'h80000000, 32'h80000000, 5'd1,  1, 0, 0, 32'hAAAA5555};
        tbl[3] = '{2, 32'h40000000, 32'h40000000, 32'h00000000, 5'd2,  1, 0, 0, 32'h0};
        tbl[4] = '{0, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'hF0F0F0F0, 5'd9,  4, 0, 1, 32'hDEADBEEF};
        tbl[5] = '{0, 32'h11111111, 32'h22222222, 32'h22222222, 5'd10, 2, 0, 0, 32'h33333333};
        tbl[6] = '{3, 32'h50000000, 32'h30000000, 32'h00000000, 5'd4,  1, 0, 0, 32'h0};
        tbl[7] = '{0, 32'h00000005, 32'h00000006, 32'h00000006, 5'd0,  2, 0, 0, 32'h0000000B};
        tbl[8] = '{1, 32'hCAFEF00D, 32'h00000000, 32'h00000000, 5'd3,  1, 2, 2, 32'h76543210};
        tbl[9] = '{1, 32'h7FFFFFFF, 32'h00000001, 32'hFFFFFFFF, 5'd31, 5, 3, 0, 32'h01020304};

        // reset state
        repeat (2) next_cycle();
        settle();
        chk("rst_dec_busy", 32'(dec_busy), 32'd0);
        chk("rst_posu_valid", 32'(posu_valid), 32'd0);
        chk("rst_posu_a", posu_a, 32'd0);
        chk("rst_posu_b", posu_b, 32'd0);
        chk("rst_posu_dp", 32'(posu_dp), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_last_lat", 32'(last_lat), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // directed vectors
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].exp_b, tbl[i].rd,
                   tbl[i].d, tbl[i].w, tbl[i].fmode, tbl[i].res);
        end

        // zero-bubble: stall 4 cycles in WB, then retire and issue together
        dec_valid = 1'b1; dec_pkt = mk_pkt(0); dec_rs1 = 32'h01010101; dec_rs2 = 32'h02020202; dec_rd = 5'd4;
        next_cycle();
        dec_valid = 1'b0; posu_finish = 1'b1; posu_out = 32'h5A5A5A5A;
        next_cycle();
        posu_finish = 1'b0; exp_lat = 1;
        for (int j = 0; j < 4; j++) begin
            settle();
            chk("zb_wb_valid", 32'(wb_valid), 32'd1);
            chk("zb_wb_stable", wb_data, 32'h5A5A5A5A);
            chk("zb_dec_busy", 32'(dec_busy), 32'd1);
            next_cycle();
        end
        wb_ready = 1'b1; dec_valid = 1'b1; dec_pkt = mk_pkt(1);
        dec_rs1 = 32'h0BADF00D; dec_rs2 = 32'h00000002; dec_rd = 5'd6;
        settle();
        chk("zb_accept_busy", 32'(dec_busy), 32'd0);
        next_cycle();
        wb_ready = 1'b0; dec_valid = 1'b0;
        settle();
        chk("zb_posu_valid", 32'(posu_valid), 32'd1);
        chk("zb_old_retired", 32'(wb_valid), 32'd0);
        chk("zb_new_a", posu_a, 32'h0BADF00D);
        chk("zb_new_b", posu_b, 32'hFFFFFFFE);
        next_cycle();
        posu_finish = 1'b1; posu_out = 32'h13579BDF;
        next_cycle();
        posu_finish = 1'b0; exp_lat = 2;
        settle();
        chk("zb2_wb_rd", 32'(wb_rd), 32'd6);
        chk("zb2_wb_data", wb_data, 32'h13579BDF);
        chk("zb2_last_lat", 32'(last_lat), 32'd2);
        wb_ready = 1'b1;
        next_cycle();
        wb_ready = 1'b0;
        settle();
        chk("zb2_retired", 32'(wb_valid), 32'd0);
        next_cycle();

`ifdef RV_POSU_TIMEOUT_EN
        dec_valid = 1'b1; dec_pkt = mk_pkt(0); dec_rd = 5'd2;
        next_cycle();
        dec_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            settle();
            chk("wd_busy", 32'(posu_valid), 32'd1);
            chk("wd_quiet", 32'(timeout), 32'd0);
            next_cycle();
        end
        settle();
        chk("wd_pulse", 32'(timeout), 32'd1);
        chk("wd_idle", 32'(posu_valid), 32'd0);
        chk("wd_no_wb", 32'(wb_valid), 32'd0);
        next_cycle();
        settle();
        chk("wd_pulse_once", 32'(timeout), 32'd0);
        chk("wd_no_wb_after", 32'(wb_valid), 32'd0);
        next_cycle();
`else
        dec_valid = 1'b1; dec_pkt = mk_pkt(0); dec_rs1 = 32'h1; dec_rs2 = 32'h2; dec_rd = 5'd2;
        next_cycle();
        dec_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            settle();
            chk("wait_busy", 32'(posu_valid), 32'd1);
            chk("wait_no_timeout", 32'(timeout), 32'd0);
            next_cycle();
        end
        posu_finish = 1'b1; posu_out = 32'h00C0FFEE;
        next_cycle();
        posu_finish = 1'b0; exp_lat = 21;
        settle();
        chk("wait_wb_data", wb_data, 32'h00C0FFEE);
        chk("wait_last_lat", 32'(last_lat), 32'd21);
        wb_ready = 1'b1;
        next_cycle();
        wb_ready = 1'b0;
`endif

        // randomized transactions against the transaction-level model
        for (int n = 0; n < 40; n++) begin
            int          op, d, w, fm;
            logic [31:0] rs1, rs2, eb, res;
            logic [63:0] t;
            logic [4:0]  rd;
            op  = int'($urandom_range(0, 3));
            rs1 = $urandom();
            rs2 = ($urandom_range(0, 4) == 0) ? 32'h80000000 : $urandom();
            rd  = 5'($urandom_range(0, 31));
            d   = int'($urandom_range(1, 6));
            w   = int'($urandom_range(0, 3));
            fm  = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 2)) : 0;
            res = $urandom();
            t   = 64'h1_0000_0000 - {32'd0, rs2};
            eb  = (op == 1) ? t[31:0] : rs2;
            run_op(op, rs1, rs2, eb, rd, d, w, fm, res);
        end

        // asynchronous reset in the middle of an op
        dec_valid = 1'b1; dec_pkt = mk_pkt(0); dec_rs1 = 32'h77777777; dec_rd = 5'd8;
        next_cycle();
        dec_valid = 1'b0;
        settle();
        chk("mid_busy", 32'(posu_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(posu_valid), 32'd0);
        chk("mid_rst_a", posu_a, 32'd0);
        chk("mid_rst_last_lat", 32'(last_lat), 32'd0);
        next_cycle();
        rst = 1'b0; posu_finish = 1'b1; posu_out = 32'hFFFFFFFF;
        settle();
        chk("mid_no_wb", 32'(wb_valid), 32'd0);
        chk("mid_no_illegal", 32'(illegal), 32'd0);
        next_cycle();
        posu_finish = 1'b0;
        settle();
        chk("stray_finish_ignored", 32'(wb_valid), 32'd0);
        chk("stray_finish_data", wb_data, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
